// File: rtl/vseq_pkg.sv
// Shared types and sizes for the vector sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vseq_pkg;

    // Number of vector slots and the matching slot-index width.
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    // Wide enough to hold a vector count of 0..DEPTH.
    localparam int CNT_W  = 5;

    // A run can fail at most once per slot, so the count tops out at DEPTH.
    localparam logic [CNT_W-1:0] MISMATCH_MAX = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/vseq_mem.sv
// Vector store: DEPTH entries of {stimulus, expected}, one write port, one async read port.
// Latency: write visible on the cycle after the write edge; read is combinational.
// Backpressure: none; the owner gates writes.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
// Contents are deliberately not reset so a loaded vector set survives rst.
module vseq_mem
    import vseq_pkg::*;
#(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vector_sequencer.sv
// Replays stored stimulus vectors to a combinational DUT, holding each for HOLD cycles and
// checking the DUT response on the last hold cycle. Latency: done in cycle T+1+N*HOLD for a
// start sampled at edge T. Backpressure: none; start and loads are ignored outside IDLE.
// Ports: clk/rst; load_en/load_addr/load_data fill the vector store; start/num_vec launch
// a run; dut_in/dut_out connect the DUT; busy/done/vec_idx report progress;
// mismatch_cnt/fail_valid/first_fail report results of the current or last run.
module vector_sequencer
    import vseq_pkg::*;
#(
    parameter int VEC_W = 2,
    parameter int OUT_W = 1,
    parameter int HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [ADDR_W-1:0]      load_addr,
    input  logic [VEC_W+OUT_W-1:0] load_data,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vec,
    output logic [VEC_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]       dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      vec_idx,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic                   fail_valid,
    output logic [ADDR_W-1:0]      first_fail
);

    localparam int DATA_W = VEC_W + OUT_W;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] vec_idx_q, vec_idx_d;
    logic [3:0]        hold_q, hold_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  mis_q, mis_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] first_q, first_d;

    logic [DATA_W-1:0] rd_dat;
    logic [VEC_W-1:0]  rd_stim;
    logic [OUT_W-1:0]  rd_exp;

    // The store is only writable between runs so a run always sees a stable vector set.
    vseq_mem #(
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (load_en && (state_q == IDLE)),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (vec_idx_q),
        .rdata (rd_dat)
    );

    assign rd_stim = rd_dat[DATA_W-1:OUT_W];
    assign rd_exp  = rd_dat[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_idx_q <= '0;
            hold_q    <= '0;
            num_q     <= '0;
            mis_q     <= '0;
            fail_q    <= 1'b0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            hold_q    <= hold_d;
            num_q     <= num_d;
            mis_q     <= mis_d;
            fail_q    <= fail_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        hold_d    = hold_q;
        num_d     = num_q;
        mis_d     = mis_q;
        fail_d    = fail_q;
        first_d   = first_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d     = num_vec;
                    vec_idx_d = '0;
                    hold_d    = '0;
                    mis_d     = '0;
                    fail_d    = 1'b0;
                    first_d   = '0;
                    state_d   = (num_vec == '0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                if (hold_q == HOLD_LAST) begin
                    // Only the last hold cycle is checked, giving the DUT time to settle.
                    if (dut_out != rd_exp) begin
                        if (mis_q != MISMATCH_MAX) begin
                            mis_d = mis_q + CNT_W'(1);
                        end
                        if (!fail_q) begin
                            fail_d  = 1'b1;
                            first_d = vec_idx_q;
                        end
                    end
                    if ({1'b0, vec_idx_q} == (num_q - CNT_W'(1))) begin
                        state_d = DONE;
                    end else begin
                        vec_idx_d = vec_idx_q + ADDR_W'(1);
                        hold_d    = '0;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dut_in       = (state_q == APPLY) ? rd_stim : '0;
    assign busy         = (state_q == APPLY);
    assign done         = (state_q == DONE);
    assign vec_idx      = vec_idx_q;
    assign mismatch_cnt = mis_q;
    assign fail_valid   = fail_q;
    assign first_fail   = first_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer with a scoreboard: runs push expected per-cycle
// stimulus and end-of-run results; a monitor pops and compares on busy/done.
// The DUT under test is a 2-input OR gate driven from dut_in.
module tb_vector_sequencer;
    import vseq_pkg::*;

    localparam int VEC_W = 2;
    localparam int OUT_W = 1;
    localparam int HOLD  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_en = 1'b0;
    logic [3:0]       load_addr = '0;
    logic [2:0]       load_data = '0;
    logic             start = 1'b0;
    logic [4:0]       num_vec = '0;
    logic [1:0]       dut_in;
    logic [0:0]       dut_out;
    logic             busy, done, fail_valid;
    logic [3:0]       vec_idx, first_fail;
    logic [4:0]       mismatch_cnt;

    assign dut_out = dut_in[1] | dut_in[0];

    vector_sequencer #(
        .VEC_W (VEC_W),
        .OUT_W (OUT_W),
        .HOLD  (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .num_vec      (num_vec),
        .dut_in       (dut_in),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .vec_idx      (vec_idx),
        .mismatch_cnt (mismatch_cnt),
        .fail_valid   (fail_valid),
        .first_fail   (first_fail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0] stim;
        logic [3:0] idx;
    } apply_t;

    typedef struct {
        int         cyc;
        logic [4:0] cnt;
        logic       fv;
        logic [3:0] ff;
    } res_t;

    apply_t     apq[$];
    res_t       rsq[$];
    logic [2:0] mem_m [16];
    int         n_vec = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every APPLY cycle consumes one expected stimulus entry, every done pulse
    // consumes one expected result record.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (apq.size() == 0) begin
                    chk("busy_unexpected", 32'(busy), 32'd0);
                end else begin
                    apply_t a;
                    a = apq.pop_front();
                    chk("dut_in", 32'(dut_in), 32'(a.stim));
                    chk("vec_idx", 32'(vec_idx), 32'(a.idx));
                end
            end else begin
                chk("dut_in_idle", 32'(dut_in), 32'd0);
            end
            if (done === 1'b1) begin
                if (rsq.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    res_t r;
                    r = rsq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(r.cyc));
                    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(r.cnt));
                    chk("fail_valid", 32'(fail_valid), 32'(r.fv));
                    if (r.fv) chk("first_fail", 32'(first_fail), 32'(r.ff));
                end
            end
        end
    end

    task automatic load(input int a, input logic [2:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        mem_m[a]  = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // abort_at > 0: assert rst so it is sampled in the abort_at-th APPLY cycle.
    // interfere: pulse load_en and start while the run is busy.
    task automatic run(input int n, input logic [4:0] ecnt, input logic efv,
                       input logic [3:0] eff, input int abort_at, input bit interfere);
        int c;
        int pushed;
        @(negedge clk);
        c = cyc;
        pushed = 0;
        for (int k = 0; k < n; k++) begin
            for (int h = 0; h < HOLD; h++) begin
                if (abort_at == 0 || pushed < abort_at) begin
                    apq.push_back(apply_t'{stim: mem_m[k][2:1], idx: 4'(k)});
                    pushed++;
                end
            end
        end
        if (abort_at == 0) begin
            rsq.push_back(res_t'{cyc: c + 1 + n * HOLD, cnt: ecnt, fv: efv, ff: eff});
        end
        num_vec = 5'(n);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else if (interfere) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 4'd1;
            load_data = 3'b110;
            start     = 1'b1;
            num_vec   = 5'd1;
            @(negedge clk);
            load_en   = 1'b0;
            start     = 1'b0;
        end
        for (int i = 0; i < 200 && (rsq.size() != 0 || apq.size() != 0); i++) @(posedge clk);
        if (rsq.size() != 0 || apq.size() != 0) begin
            chk("run_timeout", 32'(rsq.size() + apq.size()), 32'd0);
            rsq.delete();
            apq.delete();
        end
        if (abort_at == 0) begin
            // Results must persist through idle cycles after done.
            repeat (3) @(negedge clk);
            chk("hold_mismatch_cnt", 32'(mismatch_cnt), 32'(ecnt));
            chk("hold_fail_valid", 32'(fail_valid), 32'(efv));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dut_in", 32'(dut_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vec_idx", 32'(vec_idx), 32'd0);
        chk("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        chk("rst_fail_valid", 32'(fail_valid), 32'd0);
        chk("rst_first_fail", 32'(first_fail), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // OR-gate truth table, all passing.
        load(0, 3'b000);
        load(1, 3'b011);
        load(2, 3'b101);
        load(3, 3'b111);
        run(4, 5'd0, 1'b0, 4'd0, 0, 1'b0);

        // Slot 2 expects 0 but OR gives 1.
        load(2, 3'b100);
        run(4, 5'd1, 1'b1, 4'd2, 0, 1'b0);
        load(2, 3'b101);

        // Zero-length run: immediate done, previous results cleared.
        run(0, 5'd0, 1'b0, 4'd0, 0, 1'b0);

        // Reset during vector 1: no done, then memory reused intact.
        run(4, 5'd0, 1'b0, 4'd0, 3, 1'b0);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vec_idx", 32'(vec_idx), 32'd0);
        chk("abort_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        run(4, 5'd0, 1'b0, 4'd0, 0, 1'b0);

        // load_en/start while busy are ignored; memory left intact.
        run(4, 5'd0, 1'b0, 4'd0, 0, 1'b1);
        run(4, 5'd0, 1'b0, 4'd0, 0, 1'b0);

        // Full depth, every expected value wrong.
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            load(k, {kk[1:0], ~(kk[1] | kk[0])});
        end
        run(16, 5'd16, 1'b1, 4'd0, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
